// File: rtl/abd_fetch.sv
//------------------------------------------------------------------------------
// abd_fetch
//
// Instruction fetch unit. It is the requester for a synchronous-read
// instruction ROM. It buffers returned words in a small circular buffer and
// hands them to decode over a valid/ready handshake.
//
// Build option:
//   ABD_FETCH_BYPASS_EN  when defined, a word coming back from the ROM while
//                        the buffer is empty is presented to decode in the
//                        same cycle. This saves one cycle of latency after
//                        reset and after a redirect. When undefined, every
//                        word passes through the buffer registers.
//
// Ports:
//   clock           single clock, rising edge
//   reset           synchronous, active-high
//   rom_address     ROM read address (always equal to fetch_pc)
//   rom_q           ROM read data, valid one cycle after the address
//   redirect_valid  branch/jump taken: flush and restart fetch
//   redirect_pc     new fetch address, qualified by redirect_valid
//   instr_valid     instr/instr_pc hold a valid instruction
//   instr_ready     decode accepts the instruction this cycle
//   instr           instruction word, 0 when instr_valid=0
//   instr_pc        address of instr, 0 when instr_valid=0
//
// Handshake: a transfer happens on a rising edge where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0,
// instr/instr_pc stay stable; only redirect or reset may withdraw them.
//------------------------------------------------------------------------------
module abd_fetch #(
   parameter int         INSTR_WIDTH = 16,
   parameter logic [9:0] RESET_PC    = 10'd0,
   parameter int         BUF_DEPTH   = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic [9:0]             rom_address,
   input  logic [INSTR_WIDTH-1:0] rom_q,
   input  logic                   redirect_valid,
   input  logic [9:0]             redirect_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [9:0]             instr_pc
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(BUF_DEPTH);

   logic [9:0]             fetch_pc;
   logic                   inflight;
   logic [9:0]             inflight_pc;
   logic [INSTR_WIDTH-1:0] buf_instr [BUF_DEPTH];
   logic [9:0]             buf_pc    [BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;

   logic                   buf_empty;
   logic                   direct;
   logic                   pop;
   logic                   pop_buf;
   logic                   push;
   logic [CNT_W:0]         occupancy;
   logic                   issue;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign rom_address = fetch_pc;
   assign buf_empty   = (count == '0);

   // direct: the returning ROM word is shown to decode without being buffered
`ifdef ABD_FETCH_BYPASS_EN
   assign direct = buf_empty & inflight;
`else
   assign direct = 1'b0;
`endif

   always_comb begin
      instr_valid = 1'b0;
      instr       = '0;
      instr_pc    = '0;
      if (!buf_empty) begin
         instr_valid = 1'b1;
         instr       = buf_instr[rd_ptr];
         instr_pc    = buf_pc[rd_ptr];
      end else if (direct) begin
         instr_valid = 1'b1;
         instr       = rom_q;
         instr_pc    = inflight_pc;
      end
   end

   assign pop     = instr_valid & instr_ready;
   assign pop_buf = pop & !buf_empty;
   // A returning word is dropped on redirect, and skips the buffer when it
   // is consumed directly.
   assign push    = inflight & !redirect_valid & !(direct & pop);

   // Credit: words held plus the word in flight, minus the one leaving now,
   // must leave room for the word issued this cycle.
   assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
   assign issue     = !reset & !redirect_valid & (occupancy < CREDIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         // Any pop this cycle has already completed; the flush follows it.
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 10'd1;
         end
         if (push)    wr_ptr <= next_ptr(wr_ptr);
         if (pop_buf) rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop_buf})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Buffer storage carries no reset; count alone says what is valid.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         buf_instr[wr_ptr] <= rom_q;
         buf_pc[wr_ptr]    <= inflight_pc;
      end
   end

   no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && !pop_buf && count == CNT_FULL));

endmodule

// File: tb/tb_abd_fetch.sv
module tb_abd_fetch;

   localparam int DEPTH = 2;
`ifdef ABD_FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   // ---------------- clock / reset / signals ----------------
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  rom_address, rom_address2;
   logic [15:0] rom_q = '0, rom_q2 = '0;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_pc = '0;
   logic        instr_valid, instr_valid2;
   logic        instr_ready = 1'b1;
   logic [15:0] instr, instr2;
   logic [9:0]  instr_pc, instr_pc2;

   always #5 clock = ~clock;

   abd_fetch #(.INSTR_WIDTH(16), .RESET_PC(10'h000), .BUF_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .rom_address(rom_address), .rom_q(rom_q),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc));

   abd_fetch #(.INSTR_WIDTH(16), .RESET_PC(10'h3FE), .BUF_DEPTH(DEPTH)) dut2 (
      .clock(clock), .reset(reset), .rom_address(rom_address2), .rom_q(rom_q2),
      .redirect_valid(1'b0), .redirect_pc(10'h000),
      .instr_valid(instr_valid2), .instr_ready(instr_ready),
      .instr(instr2), .instr_pc(instr_pc2));

   // Synchronous ROMs: ROM[i] = i + 16'h1000
   always @(posedge clock) begin
      rom_q  <= 16'h1000 + {6'b0, rom_address};
      rom_q2 <= 16'h1000 + {6'b0, rom_address2};
   end

   // ---------------- check helpers ----------------
   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_ok(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   // The accepted stream must be consecutive PCs from the reset PC, restarting
   // at redirect_pc after each redirect (after any pop in that cycle).
   logic [9:0]  exp_next = 10'h000;
   logic [9:0]  acc_q[$];
   int          acc_cnt = 0;
   logic        prev_reset = 1'b1;
   logic        prev_hold = 1'b0;
   logic [9:0]  prev_pc = '0;
   logic [15:0] prev_instr = '0;
   int          starve = 0;
   logic [9:0]  outstanding;

   logic [9:0]  exp2 = 10'h3FE;
   logic [9:0]  got2_q[$];
   logic [9:0]  exp_q[$];

   always @(negedge clock) begin
      if (reset) begin
         exp_next   = 10'h000;
         prev_reset = 1'b1;
         prev_hold  = 1'b0;
         starve     = 0;
      end else begin
         if (prev_reset) check_eq("post_reset_valid", 32'(instr_valid), 32'd0);
         if (!instr_valid)
            check_eq("idle_zero", {6'b0, instr_pc, instr}, 32'd0);
         else
            check_eq("instr_data", 32'(instr), 32'(16'h1000 + {6'b0, instr_pc}));
         if (prev_hold)
            check_eq("stall_stable", {5'b0, instr_valid, instr_pc, instr}, {5'b0, 1'b1, prev_pc, prev_instr});
         outstanding = rom_address - exp_next;
         check_ok(outstanding <= 10'(DEPTH), "credit", 32'(outstanding), 32'(DEPTH));
         if (instr_valid && instr_ready) begin
            check_eq("order", 32'(instr_pc), 32'(exp_next));
            acc_q.push_back(instr_pc);
            acc_cnt++;
            exp_next = exp_next + 10'd1;
         end
         if (redirect_valid) exp_next = redirect_pc;
         if ((instr_valid && instr_ready) || redirect_valid) starve = 0;
         else if (instr_ready) starve++;
         if (starve > 4) begin
            check_eq("starve", 32'(starve), 32'd4);
            starve = 0;
         end
         prev_hold  = instr_valid & !instr_ready & !redirect_valid;
         prev_pc    = instr_pc;
         prev_instr = instr;
         prev_reset = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         exp2 = 10'h3FE;
         got2_q.delete();
      end else if (instr_valid2 && instr_ready) begin
         check_eq("order2", 32'(instr_pc2), 32'(exp2));
         check_eq("instr_data2", 32'(instr2), 32'(16'h1000 + {6'b0, instr_pc2}));
         got2_q.push_back(instr_pc2);
         exp2 = exp2 + 10'd1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Caller sits at a negedge; counts cycles until instr_valid is seen.
   task automatic first_valid(output int lat);
      lat = 0;
      while (!instr_valid && lat < 10) begin
         tick();
         @(negedge clock);
         lat++;
      end
   endtask

   typedef struct {
      logic [9:0] target;
      int         stall;
      logic       ready_r;
      logic [9:0] exp_addr;
      int         exp_lat;
   } redir_vec_t;

   redir_vec_t vecs[4];

   initial begin
      int lat;
      int acc0;
      logic [9:0] addr_a;

      vecs[0] = '{10'h200, 3, 1'b0, 10'h200, LAT + 1};
      vecs[1] = '{10'h3FF, 0, 1'b1, 10'h3FF, LAT + 1};
      vecs[2] = '{10'h010, 1, 1'b1, 10'h010, LAT + 1};
      vecs[3] = '{10'h123, 5, 1'b0, 10'h123, LAT + 1};

      // ---- reset values and first-instruction latency ----
      reset = 1'b1;
      instr_ready = 1'b1;
      tick();
      @(negedge clock);
      check_eq("reset_outputs", {5'b0, instr_valid, instr_pc, instr}, 32'd0);
      check_eq("reset_rom_address", 32'(rom_address), 32'h000);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check_eq("cycle0_rom_address", 32'(rom_address), 32'h000);
      check_eq("cycle0_rom_address2", 32'(rom_address2), 32'h3FE);
      check_eq("cycle0_valid", 32'(instr_valid), 32'd0);
      first_valid(lat);
      check_eq("first_latency", 32'(lat), 32'(LAT));
      check_eq("first_pc", 32'(instr_pc), 32'h000);

      // ---- throughput with instr_ready=1 ----
      repeat (3) tick();
      acc0 = acc_cnt;
      repeat (8) tick();
      check_eq("throughput", 32'(acc_cnt - acc0), 32'd8);
      exp_q = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      check_ok(got2_q.size() >= 4, "wrap_count", 32'(got2_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got2_q.size(); i++)
         check_eq("wrap_seq", 32'(got2_q[i]), 32'(exp_q[i]));

      // ---- 6-cycle stall mid-stream ----
      instr_ready = 1'b0;
      acc0 = acc_cnt;
      repeat (3) tick();
      @(negedge clock);
      addr_a = rom_address;
      repeat (3) tick();
      @(negedge clock);
      check_eq("stall_pc_frozen", 32'(rom_address), 32'(addr_a));
      check_eq("stall_no_accept", 32'(acc_cnt - acc0), 32'd0);
      instr_ready = 1'b1;
      repeat (6) tick();
      check_eq("stall_resume", 32'(acc_cnt - acc0), 32'd6);

      // ---- redirect vectors ----
      foreach (vecs[k]) begin
         instr_ready = 1'b1;
         repeat (3) tick();
         instr_ready = 1'b0;
         repeat (vecs[k].stall) tick();
         instr_ready    = vecs[k].ready_r;
         redirect_valid = 1'b1;
         redirect_pc    = vecs[k].target;
         tick();
         redirect_valid = 1'b0;
         instr_ready    = 1'b0;
         @(negedge clock);
         check_eq("redir_rom_address", 32'(rom_address), 32'(vecs[k].exp_addr));
         check_eq("redir_valid_r1", 32'(instr_valid), 32'd0);
         first_valid(lat);
         check_eq("redir_latency", 32'(lat + 1), 32'(vecs[k].exp_lat));
         check_eq("redir_pc", 32'(instr_pc), 32'(vecs[k].target));
      end

      // ---- redirect in the same cycle as the pop of 10'h005 ----
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 10'h003;
      tick();
      redirect_valid = 1'b0;
      acc_q.delete();
      repeat (LAT + 2) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 10'h100;
      @(negedge clock);
      check_eq("pop005_present", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'h005});
      tick();
      redirect_valid = 1'b0;
      @(negedge clock);
      check_eq("pop005_gap", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 10 && acc_q.size() < 4; i++) tick();
      exp_q = '{10'h003, 10'h004, 10'h005, 10'h100};
      check_eq("pop005_count", 32'(acc_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         check_eq("pop005_seq", 32'(acc_q[i]), 32'(exp_q[i]));

      // ---- reset during a stall with words buffered ----
      instr_ready = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check_eq("midreset_valid", 32'(instr_valid), 32'd0);
      check_eq("midreset_rom_address", 32'(rom_address), 32'h000);
      instr_ready = 1'b1;
      first_valid(lat);
      check_eq("midreset_latency", 32'(lat), 32'(LAT));
      check_eq("midreset_pc", 32'(instr_pc), 32'h000);

      // ---- randomized traffic against the stream model ----
      acc0 = acc_cnt;
      for (int i = 0; i < 1500; i++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 39) == 0);
         redirect_pc    = 10'($urandom_range(0, 1023));
         reset          = ($urandom_range(0, 299) == 0);
         tick();
      end
      redirect_valid = 1'b0;
      reset          = 1'b0;
      instr_ready    = 1'b1;
      repeat (6) tick();
      check_ok((acc_cnt - acc0) > 300, "random_progress", 32'(acc_cnt - acc0), 32'd300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
